// File: rtl/mem_bus_arbiter_pkg.sv
// Shared core types for the memory-map port and the debug arbiter.
//   addr_t / data_t : default 32-bit address and data words
//   arb_state_t     : arbiter state encoding, visible to debug logic and benches
package mem_bus_arbiter_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] data_t;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DBG    = 2'd1,
    RESP   = 2'd2,
    HALTED = 2'd3
  } arb_state_t;

endpackage

// File: rtl/mem_bus_arbiter.sv
// Shares the single memory-map port between the core and the UART debug
// master, and owns the core's run/halt state.
//   core_*      : core request, read data passthrough, stall
//   dbg_*       : debug request/ack handshake with captured read data
//   halt_req    : level, park the core; resume_req: pulse, release it
//   halted      : high while parked
//   mem_*       : shared memory-map port (combinational read data)
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH    = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int MAX_DBG_BURST = 4,
  parameter int RESET_HALTED  = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [ADDR_WIDTH-1:0]   core_addr,
  input  logic [DATA_WIDTH-1:0]   core_wdata,
  input  logic [DATA_WIDTH/8-1:0] core_we,
  output logic [DATA_WIDTH-1:0]   core_rdata,
  output logic                    core_stall,
  input  logic                    dbg_req,
  input  logic [ADDR_WIDTH-1:0]   dbg_addr,
  input  logic [DATA_WIDTH-1:0]   dbg_wdata,
  input  logic [DATA_WIDTH/8-1:0] dbg_we,
  output logic                    dbg_ack,
  output logic [DATA_WIDTH-1:0]   dbg_rdata,
  input  logic                    halt_req,
  input  logic                    resume_req,
  output logic                    halted,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_we,
  input  logic [DATA_WIDTH-1:0]   mem_rdata
);

  localparam int CW = $clog2(MAX_DBG_BURST + 1);
  localparam logic [CW-1:0] BURST_MAX = CW'(MAX_DBG_BURST);
  localparam arb_state_t RST_STATE = (RESET_HALTED != 0) ? HALTED : RUN;

  arb_state_t    state, state_nxt;
  logic          halt_pend, halt_pend_nxt;
  logic [CW-1:0] burst_cnt, burst_cnt_nxt;

  // Outputs other than the bus mux decode from state only, so there is no
  // combinational path from any input to core_stall.
  assign core_stall = (state != RUN);
  assign halted     = (state == HALTED);
  assign dbg_ack    = (state == RESP);
  assign core_rdata = mem_rdata;

  always_comb begin
    state_nxt     = state;
    halt_pend_nxt = halt_pend;
    burst_cnt_nxt = burst_cnt;
    mem_addr      = dbg_addr;
    mem_wdata     = dbg_wdata;
    mem_we        = '0;

    case (state)
      RUN: begin
        mem_addr  = core_addr;
        mem_wdata = core_wdata;
        mem_we    = core_we;
        if (dbg_req && (burst_cnt < BURST_MAX)) begin
          state_nxt     = DBG;
          burst_cnt_nxt = burst_cnt + CW'(1);
          halt_pend_nxt = halt_req;
        end else begin
          // Any RUN cycle without a debug access (including the forced one
          // at saturation) restarts the burst window.
          burst_cnt_nxt = '0;
          if (halt_req) begin
            state_nxt     = HALTED;
            halt_pend_nxt = 1'b0;
          end
        end
      end
      DBG: begin
        mem_we    = dbg_we;
        state_nxt = RESP;
      end
      RESP: begin
        // dbg_req is still high from the acked request; do not sample it.
        if (halt_pend) begin
          state_nxt     = HALTED;
          halt_pend_nxt = 1'b0;
          burst_cnt_nxt = '0;
        end else begin
          state_nxt = RUN;
        end
      end
      HALTED: begin
        if (dbg_req) begin
          // halt_pend doubles as "return to HALTED after RESP"; accesses
          // made while parked are not counted against the burst limit.
          state_nxt     = DBG;
          halt_pend_nxt = 1'b1;
        end else if (resume_req && !halt_req) begin
          state_nxt = RUN;
        end
      end
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RST_STATE;
      halt_pend <= 1'b0;
      burst_cnt <= '0;
      dbg_rdata <= '0;
    end else begin
      state     <= state_nxt;
      halt_pend <= halt_pend_nxt;
      burst_cnt <= burst_cnt_nxt;
      if (state == DBG) dbg_rdata <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: debug read data is scoreboarded
// (expected values queued at issue, popped on dbg_ack), while stall, halt and
// bus-mux behaviour is checked cycle by cycle against hand-computed values.
module tb_mem_bus_arbiter;
  import mem_bus_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] core_addr, core_wdata, core_rdata;
  logic [3:0]  core_we;
  logic        core_stall;
  logic        dbg_req, dbg_ack;
  logic [31:0] dbg_addr, dbg_wdata, dbg_rdata;
  logic [3:0]  dbg_we;
  logic        halt_req, resume_req, halted;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_we;

  // second instance, reset-halted flavour
  logic        halt_h, resume_h, halted_h, core_stall_h, dbg_ack_h;
  logic [31:0] core_rdata_h, dbg_rdata_h, mem_addr_h, mem_wdata_h;
  logic [31:0] mem_rdata_h = 32'h0;
  logic [3:0]  mem_we_h;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mem [0:255];

  always #5 clk = ~clk;

  mem_bus_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_DBG_BURST(4), .RESET_HALTED(0)) dut (
    .clk(clk), .rst_n(rst_n),
    .core_addr(core_addr), .core_wdata(core_wdata), .core_we(core_we),
    .core_rdata(core_rdata), .core_stall(core_stall),
    .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata), .dbg_we(dbg_we),
    .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
    .halt_req(halt_req), .resume_req(resume_req), .halted(halted),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
  );

  mem_bus_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_DBG_BURST(4), .RESET_HALTED(1)) dut_h (
    .clk(clk), .rst_n(rst_n),
    .core_addr(core_addr), .core_wdata(core_wdata), .core_we(core_we),
    .core_rdata(core_rdata_h), .core_stall(core_stall_h),
    .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata), .dbg_we(dbg_we),
    .dbg_ack(dbg_ack_h), .dbg_rdata(dbg_rdata_h),
    .halt_req(halt_h), .resume_req(resume_h), .halted(halted_h),
    .mem_addr(mem_addr_h), .mem_wdata(mem_wdata_h), .mem_we(mem_we_h), .mem_rdata(mem_rdata_h)
  );

  // word-addressed memory map model, combinational read, byte-lane write
  assign mem_rdata = mem[mem_addr[9:2]];
  always @(posedge clk) begin
    for (int b = 0; b < 4; b++)
      if (mem_we[b]) mem[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // scoreboard monitor: every ack must match the oldest queued expectation
  always @(negedge clk) begin
    if (dbg_ack) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_ack actual=ack expected=no_ack rdata=%h", dbg_rdata);
      end else begin
        check("dbg_rdata", dbg_rdata, exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  logic [0:15] stall_pat;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[8] = 32'h12345678;  // address 0x20
    rst_n = 1'b0;
    core_addr = 32'h0; core_wdata = 32'h0; core_we = 4'h0;
    dbg_req = 1'b0; dbg_addr = 32'h0; dbg_wdata = 32'h0; dbg_we = 4'h0;
    halt_req = 1'b0; resume_req = 1'b0; halt_h = 1'b0; resume_h = 1'b0;

    // reset state
    repeat (2) step();
    @(negedge clk);
    check("rst_stall", core_stall, 0);
    check("rst_halted", halted, 0);
    check("rst_ack", dbg_ack, 0);
    check("rst_rdata", dbg_rdata, 0);
    check("rsth_halted", halted_h, 1);
    check("rsth_stall", core_stall_h, 1);

    // reset-halted instance: stays parked, gates core writes
    step();
    rst_n = 1'b1;
    core_addr = 32'h40; core_wdata = 32'h0; core_we = 4'hF;
    @(negedge clk);
    check("rsth_mem_we", mem_we_h, 0);
    check("rsth_halted_after", halted_h, 1);
    step(); halt_h = 1'b1; resume_h = 1'b1;
    step(); halt_h = 1'b0; resume_h = 1'b0;
    @(negedge clk);
    check("halt_wins_resume", halted_h, 1);
    check("halt_wins_stall", core_stall_h, 1);
    step(); resume_h = 1'b1;
    step(); resume_h = 1'b0;
    @(negedge clk);
    check("resume_halted", halted_h, 0);
    check("resume_stall", core_stall_h, 0);
    check("resume_mem_we", mem_we_h, 4'hF);

    // core write passthrough
    step();
    core_addr = 32'h10; core_wdata = 32'hDEADBEEF; core_we = 4'hF;
    @(negedge clk);
    check("core_mem_addr", mem_addr, 32'h10);
    check("core_mem_wdata", mem_wdata, 32'hDEADBEEF);
    check("core_mem_we", mem_we, 4'hF);
    check("core_stall_run", core_stall, 0);
    step(); core_we = 4'h0;
    @(negedge clk);
    check("core_rdata", core_rdata, 32'hDEADBEEF);
    check("core_mem_we_off", mem_we, 0);

    // debug read while running
    step();
    dbg_req = 1'b1; dbg_addr = 32'h20; dbg_we = 4'h0; dbg_wdata = 32'h0;
    exp_q.push_back(32'h12345678);
    @(negedge clk); check("dr_c0_stall", core_stall, 0);
    step(); @(negedge clk);
    check("dr_c1_stall", core_stall, 1);
    check("dr_c1_addr", mem_addr, 32'h20);
    check("dr_c1_ack", dbg_ack, 0);
    step(); @(negedge clk);
    check("dr_c2_stall", core_stall, 1);
    check("dr_c2_ack", dbg_ack, 1);
    step(); dbg_req = 1'b0;
    @(negedge clk);
    check("dr_c3_stall", core_stall, 0);
    check("dr_c3_addr", mem_addr, 32'h10);
    check("dr_c3_rdata_held", dbg_rdata, 32'h12345678);

    // held request: four accesses, then two unstalled cycles back to back
    stall_pat = 16'b0110110110110011;
    step();
    dbg_req = 1'b1;
    repeat (5) exp_q.push_back(32'h12345678);
    for (int c = 0; c < 16; c++) begin
      if (c > 0) step();
      @(negedge clk);
      check($sformatf("burst_stall_c%0d", c), core_stall, stall_pat[c]);
      if (c == 12) check("burst_core_addr", mem_addr, 32'h10);
    end
    step(); dbg_req = 1'b0;
    @(negedge clk); check("burst_end_stall", core_stall, 0);

    // halt + debug write together
    step();
    halt_req = 1'b1; dbg_req = 1'b1; dbg_addr = 32'h0; dbg_wdata = 32'h13; dbg_we = 4'hF;
    exp_q.push_back(32'h0);
    step(); halt_req = 1'b0;
    @(negedge clk);
    check("hd_c1_we", mem_we, 4'hF);
    check("hd_c1_addr", mem_addr, 32'h0);
    check("hd_c1_wdata", mem_wdata, 32'h13);
    check("hd_c1_halted", halted, 0);
    step(); @(negedge clk);
    check("hd_c2_ack", dbg_ack, 1);
    check("hd_c2_we", mem_we, 0);
    step(); dbg_req = 1'b0; dbg_we = 4'h0;
    @(negedge clk);
    check("hd_c3_halted", halted, 1);
    check("hd_c3_stall", core_stall, 1);
    check("hd_c3_we", mem_we, 0);
    check("hd_mem0", mem[0], 32'h13);

    // debug read while parked returns to HALTED
    step(); dbg_req = 1'b1; dbg_addr = 32'h20;
    exp_q.push_back(32'h12345678);
    step(); step();
    @(negedge clk); check("hr_ack", dbg_ack, 1);
    step(); dbg_req = 1'b0;
    @(negedge clk); check("hr_halted", halted, 1);
    step(); resume_req = 1'b1;
    @(negedge clk); check("res_c0_halted", halted, 1);
    step(); resume_req = 1'b0;
    @(negedge clk);
    check("res_c1_halted", halted, 0);
    check("res_c1_stall", core_stall, 0);
    check("res_c1_addr", mem_addr, 32'h10);

    // reset during DBG: write abandoned, no ack
    step();
    dbg_req = 1'b1; dbg_addr = 32'h30; dbg_wdata = 32'hAAAA5555; dbg_we = 4'hF;
    step();
    @(negedge clk); check("rd_c1_we", mem_we, 4'hF);
    #1;
    rst_n = 1'b0; dbg_req = 1'b0; dbg_we = 4'h0;
    #1;
    check("rd_stall", core_stall, 0);
    check("rd_ack", dbg_ack, 0);
    check("rd_rdata", dbg_rdata, 0);
    check("rd_halted", halted, 0);
    step(); @(negedge clk);
    check("rd_ack_next", dbg_ack, 0);
    check("rd_no_commit", mem[12], 32'h0);
    step(); rst_n = 1'b1;
    step();

    check("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
